// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I decode stage feeding the ALU, buffered by a small FIFO.
// Decode is combinational on i_inst; the decoded entry is captured at push and presented from the head.
module alu_decode_stage #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [2:0]  o_opsel,
    output logic        o_sub,
    output logic        o_unsigned,
    output logic        o_arith,
    output logic [1:0]  o_op1_sel,
    output logic        o_op2_imm,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_rd_wen,
    output logic [31:0] o_pc,
    output logic        o_illegal
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 90;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic [2:0]  w_funct3;
    logic [2:0]  w_opsel;
    logic        w_sub;
    logic        w_unsigned;
    logic        w_arith;
    logic [1:0]  w_op1_sel;
    logic        w_op2_imm;
    logic [31:0] w_imm;
    logic        w_wen_raw;
    logic        w_rd_wen;
    logic        w_illegal;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [EW-1:0] w_entry;
    logic        w_push;
    logic        w_pop;

    assign w_funct3 = i_inst[14:12];
    assign w_imm_i  = {{20{i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s  = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b  = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u  = {i_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    always_comb begin
        w_opsel    = 3'b000;
        w_sub      = 1'b0;
        w_unsigned = 1'b0;
        w_arith    = 1'b0;
        w_op1_sel  = 2'b00;
        w_op2_imm  = 1'b0;
        w_imm      = 32'h0;
        w_wen_raw  = 1'b0;
        w_illegal  = 1'b0;
        case (i_inst[6:0])
            OPC_OP: begin
                w_opsel    = w_funct3;
                w_sub      = i_inst[30] & (w_funct3 == 3'b000);
                w_arith    = i_inst[30] & (w_funct3 == 3'b101);
                w_unsigned = (w_funct3 == 3'b011);
                w_wen_raw  = 1'b1;
            end
            OPC_OP_IMM: begin
                w_opsel    = w_funct3;
                w_arith    = i_inst[30] & (w_funct3 == 3'b101);
                w_unsigned = (w_funct3 == 3'b011);
                w_op2_imm  = 1'b1;
                w_imm      = w_imm_i;
                w_wen_raw  = 1'b1;
            end
            OPC_LOAD, OPC_JALR: begin
                w_op2_imm  = 1'b1;
                w_imm      = w_imm_i;
                w_wen_raw  = 1'b1;
            end
            OPC_STORE: begin
                w_op2_imm  = 1'b1;
                w_imm      = w_imm_s;
            end
            OPC_BRANCH: begin
                w_sub      = 1'b1;
                w_unsigned = w_funct3[1];
                w_imm      = w_imm_b;
            end
            OPC_LUI: begin
                w_op1_sel  = 2'b10;
                w_op2_imm  = 1'b1;
                w_imm      = w_imm_u;
                w_wen_raw  = 1'b1;
            end
            OPC_AUIPC: begin
                w_op1_sel  = 2'b01;
                w_op2_imm  = 1'b1;
                w_imm      = w_imm_u;
                w_wen_raw  = 1'b1;
            end
            OPC_JAL: begin
                w_op1_sel  = 2'b01;
                w_op2_imm  = 1'b1;
                w_imm      = w_imm_j;
                w_wen_raw  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // x0 is never a real write target
    assign w_rd_wen = w_wen_raw & (|i_inst[11:7]);

    assign w_entry = {w_opsel, w_sub, w_unsigned, w_arith, w_op1_sel, w_op2_imm, w_imm,
                      i_inst[19:15], i_inst[24:20], i_inst[11:7], w_rd_wen, i_pc, w_illegal};

    assign o_ready = (r_count < DEPTH_C);
    assign o_valid = (r_count != '0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign {o_opsel, o_sub, o_unsigned, o_arith, o_op1_sel, o_op2_imm, o_imm,
            o_rs1, o_rs2, o_rd, o_rd_wen, o_pc, o_illegal} = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - scoreboard bench for alu_decode_stage with a spec-level decode model.
module tb_alu_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_inst = '0;
    logic [31:0] i_pc = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [2:0]  o_opsel;
    logic        o_sub, o_unsigned, o_arith, o_op2_imm, o_rd_wen, o_illegal;
    logic [1:0]  o_op1_sel;
    logic [31:0] o_imm, o_pc;
    logic [4:0]  o_rs1, o_rs2, o_rd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  opsel;
        logic        sub, uns, arith;
        logic [1:0]  op1;
        logic        op2imm;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        wen;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t q[$];

    alu_decode_stage #(.DEPTH(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst(i_inst), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready),
        .o_opsel(o_opsel), .o_sub(o_sub), .o_unsigned(o_unsigned), .o_arith(o_arith),
        .o_op1_sel(o_op1_sel), .o_op2_imm(o_op2_imm), .o_imm(o_imm),
        .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_rd_wen(o_rd_wen),
        .o_pc(o_pc), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode: immediates built from signed arithmetic, classes from mnemonic groups.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [31:0] sx;
        logic [2:0]  f3;
        bit writes;
        sx = ($signed(inst) >>> 31);
        f3 = inst[14:12];
        e = '{opsel: 3'd0, sub: 1'b0, uns: 1'b0, arith: 1'b0, op1: 2'd0, op2imm: 1'b0,
              imm: 32'd0, rs1: inst[19:15], rs2: inst[24:20], rd: inst[11:7],
              wen: 1'b0, pc: pc, ill: 1'b0};
        writes = 0;
        case (inst[6:0])
            7'h33: begin
                e.opsel = f3; e.sub = inst[30] && f3 == 0; e.arith = inst[30] && f3 == 5;
                e.uns = (f3 == 3); writes = 1;
            end
            7'h13: begin
                e.opsel = f3; e.arith = inst[30] && f3 == 5; e.uns = (f3 == 3);
                e.op2imm = 1; e.imm = 32'($signed(inst) >>> 20); writes = 1;
            end
            7'h03, 7'h67: begin
                e.op2imm = 1; e.imm = 32'($signed(inst) >>> 20); writes = 1;
            end
            7'h23: begin
                e.op2imm = 1;
                e.imm = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
            end
            7'h63: begin
                e.sub = 1; e.uns = f3[1];
                e.imm = (sx << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            end
            7'h37: begin
                e.op1 = 2; e.op2imm = 1; e.imm = inst & 32'hFFFFF000; writes = 1;
            end
            7'h17: begin
                e.op1 = 1; e.op2imm = 1; e.imm = inst & 32'hFFFFF000; writes = 1;
            end
            7'h6F: begin
                e.op1 = 1; e.op2imm = 1; writes = 1;
                e.imm = (sx << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            end
            default: e.ill = 1;
        endcase
        e.wen = writes && (inst[11:7] != 0);
        return e;
    endfunction

    task automatic cmp_entry(input exp_t e);
        chk("opsel",    32'(o_opsel),    32'(e.opsel));
        chk("sub",      32'(o_sub),      32'(e.sub));
        chk("unsigned", 32'(o_unsigned), 32'(e.uns));
        chk("arith",    32'(o_arith),    32'(e.arith));
        chk("op1_sel",  32'(o_op1_sel),  32'(e.op1));
        chk("op2_imm",  32'(o_op2_imm),  32'(e.op2imm));
        chk("imm",      o_imm,           e.imm);
        chk("rs1",      32'(o_rs1),      32'(e.rs1));
        chk("rs2",      32'(o_rs2),      32'(e.rs2));
        chk("rd",       32'(o_rd),       32'(e.rd));
        chk("rd_wen",   32'(o_rd_wen),   32'(e.wen));
        chk("pc",       o_pc,            e.pc);
        chk("illegal",  32'(o_illegal),  32'(e.ill));
    endtask

    // Monitor: occupancy, head compare on pop, stability under stall, then record new pushes.
    logic [89:0] prev_out;
    bit          have_prev = 0;
    wire  [89:0] cur_out = {o_opsel, o_sub, o_unsigned, o_arith, o_op1_sel, o_op2_imm, o_imm,
                            o_rs1, o_rs2, o_rd, o_rd_wen, o_pc, o_illegal};

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            have_prev = 0;
        end else begin
            chk("o_valid_occ", 32'(o_valid), 32'(q.size() != 0));
            chk("o_ready_occ", 32'(o_ready), 32'(q.size() < 2));
            if (have_prev) begin
                n_tests++;
                if (cur_out !== prev_out) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h expected %h", cur_out, prev_out);
                end
            end
            have_prev = o_valid && !i_ready;
            prev_out  = cur_out;
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pop_empty: got o_valid=1 expected no entry");
                end else begin
                    cmp_entry(q.pop_front());
                end
            end
            if (i_valid && o_ready) q.push_back(model(i_inst, i_pc));
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        i_valid = 1; i_inst = inst; i_pc = pc;
        cyc();
        i_valid = 0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] opc [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = opc[k];
        return w;
    endfunction

    initial begin
        int acc;
        logic [31:0] bp [3] = '{32'h00500093, 32'h00A00113, 32'h00F00193};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_fields", 32'(|cur_out), 0);
        rst_n = 1;
        chk("rst_ready", 32'(o_ready), 1);

        i_ready = 1;
        send(32'h002081B3, 32'h100);
        chk("add_lat_valid", 32'(o_valid), 1);
        chk("add_rd", 32'(o_rd), 3);
        chk("add_wen", 32'(o_rd_wen), 1);
        send(32'h402081B3, 32'h104);
        chk("sub_sub", 32'(o_sub), 1);
        send(32'h40435293, 32'h108);
        chk("srai_opsel", 32'(o_opsel), 5);
        chk("srai_arith", 32'(o_arith), 1);
        chk("srai_imm", o_imm, 32'h00000404);
        send(32'hFE20EEE3, 32'h10C);
        chk("bltu_uns", 32'(o_unsigned), 1);
        chk("bltu_imm", o_imm, 32'hFFFFFFFC);
        chk("bltu_wen", 32'(o_rd_wen), 0);
        send(32'h123452B7, 32'h110);
        chk("lui_op1", 32'(o_op1_sel), 2);
        chk("lui_imm", o_imm, 32'h12345000);
        send(32'h00000000, 32'h114);
        chk("zero_ill", 32'(o_illegal), 1);
        chk("zero_wen", 32'(o_rd_wen), 0);
        send(32'h00000013, 32'h118);
        chk("nop_ill", 32'(o_illegal), 0);
        chk("nop_wen", 32'(o_rd_wen), 0);
        cyc();

        // Backpressure: three offered, two accepted, drained in order once i_ready rises.
        i_ready = 0;
        acc = 0;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            bit take;
            i_valid = 1; i_inst = bp[acc]; i_pc = 32'h200 + 32'(acc * 4);
            take = o_ready;
            cyc();
            if (take) acc++;
            if (c == 4) begin
                chk("bp_full_ready", 32'(o_ready), 0);
                chk("bp_head_rd", 32'(o_rd), 1);
                i_ready = 1;
            end
        end
        i_valid = 0;
        chk("bp_all_accepted", 32'(acc), 3);
        repeat (3) cyc();

        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_inst  = rand_inst();
            i_pc    = $urandom;
            cyc();
        end
        i_valid = 0; i_ready = 1;
        repeat (4) cyc();
        chk("drain_empty", 32'(q.size()), 0);

        // Fill both entries then reset mid-cycle.
        i_ready = 0;
        send(32'h00208233, 32'h300);
        send(32'h003102B3, 32'h304);
        chk("fill_valid", 32'(o_valid), 1);
        chk("fill_ready", 32'(o_ready), 0);
        #2;
        rst_n = 0;
        #1;
        chk("async_valid", 32'(o_valid), 0);
        chk("async_fields", 32'(|cur_out), 0);
        cyc();
        rst_n = 1;
        chk("post_rst_ready", 32'(o_ready), 1);
        chk("post_rst_valid", 32'(o_valid), 0);
        i_ready = 1;
        repeat (4) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
